// File: rtl/tt_um_hoene_input_arbiter_pkg.sv
// Shared encodings for the input arbiter and the downstream protocol selector.
package tt_um_hoene_input_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t GRANT_A = 2'd1;
  localparam arb_state_t GRANT_B = 2'd2;
  localparam arb_state_t GUARD   = 2'd3;

  localparam logic SRC_DIN = 1'b1;
  localparam logic SRC_BIN = 1'b0;

endpackage

// File: rtl/tt_um_hoene_arbiter_timer.sv
// Shared timeout/guard counter: clears on request, otherwise increments; flags the limit.
module tt_um_hoene_arbiter_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = clr_i ? '0 : cnt_q + CNT_W'(1);
  assign tc_o  = (cnt_q == limit_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tt_um_hoene_input_arbiter.sv
// Grants one decoded Manchester stream (A=DIN, B=BIN) to the protocol selector at frame
// boundaries, with a guard gap between grants and a watchdog on stalled frames.
//
//   state   | meaning
//   IDLE    | no grant; waiting for an armed stream to raise sync (A wins ties)
//   GRANT_A | DIN forwarded through the output registers
//   GRANT_B | BIN forwarded through the output registers
//   GUARD   | outputs forced low for GUARD_CYCLES before the next grant
module tt_um_hoene_input_arbiter
  import tt_um_hoene_input_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GUARD_CYCLES   = 16,
  parameter int CNT_W          = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_data,
  input  logic       a_clk,
  input  logic       a_sync,
  input  logic       b_data,
  input  logic       b_clk,
  input  logic       b_sync,
  output logic       out_data,
  output logic       out_clk,
  output logic       out_sync,
  output logic       in0selected,
  output logic       stall_err,
  output logic [7:0] switch_count
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GD_LIMIT = CNT_W'(GUARD_CYCLES - 1);

  arb_state_t state_q, state_d;
  logic       armed_a_q, armed_a_d, armed_b_q, armed_b_d;
  logic       out_data_q, out_data_d, out_clk_q, out_clk_d, out_sync_q, out_sync_d;
  logic       in0sel_q, in0sel_d, stall_q, stall_d;
  logic [7:0] sw_cnt_q, sw_cnt_d;

  logic             tmr_clr, tmr_tc;
  logic [CNT_W-1:0] tmr_limit;
  logic             granted, g_data, g_clk, g_sync;
  logic             grant_a, grant_b, grant_src, timeout;

  assign granted = (state_q == GRANT_A) || (state_q == GRANT_B);
  assign g_data  = (state_q == GRANT_B) ? b_data : a_data;
  assign g_clk   = (state_q == GRANT_B) ? b_clk  : a_clk;
  assign g_sync  = (state_q == GRANT_B) ? b_sync : a_sync;

  assign grant_a   = (state_q == IDLE) && armed_a_q && a_sync;
  assign grant_b   = (state_q == IDLE) && !grant_a && armed_b_q && b_sync;
  assign grant_src = grant_a ? SRC_DIN : SRC_BIN;
  // A strobe in the final cycle counts as activity, so it never trips the watchdog.
  assign timeout   = granted && g_sync && !g_clk && tmr_tc;

  tt_um_hoene_arbiter_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (tmr_clr),
    .limit_i (tmr_limit),
    .tc_o    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_a)      state_d = GRANT_A;
        else if (grant_b) state_d = GRANT_B;
      end
      GRANT_A, GRANT_B: if (!g_sync || timeout) state_d = GUARD;
      GUARD:            if (tmr_tc) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data_d = 1'b0;
    out_clk_d  = 1'b0;
    out_sync_d = 1'b0;
    armed_a_d  = armed_a_q | ~a_sync;
    armed_b_d  = armed_b_q | ~b_sync;
    in0sel_d   = in0sel_q;
    stall_d    = stall_q;
    sw_cnt_d   = sw_cnt_q;
    tmr_clr    = 1'b1;
    tmr_limit  = GD_LIMIT;
    case (state_q)
      IDLE: begin
        if (grant_a) armed_a_d = 1'b0;
        if (grant_b) armed_b_d = 1'b0;
        if (grant_a || grant_b) begin
          in0sel_d = grant_src;
          if (grant_src != in0sel_q && sw_cnt_q != 8'hFF) sw_cnt_d = sw_cnt_q + 8'd1;
        end
      end
      GRANT_A, GRANT_B: begin
        tmr_limit = TO_LIMIT;
        tmr_clr   = g_clk || !g_sync || timeout;
        if (timeout) begin
          stall_d = 1'b1;
        end else begin
          out_data_d = g_data;
          out_clk_d  = g_clk;
          // Keep sync up alongside a strobe that coincides with the falling sync.
          out_sync_d = g_sync | g_clk;
        end
      end
      GUARD:   tmr_clr = tmr_tc;
      default: tmr_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= 1'b0;
      out_clk_q  <= 1'b0;
      out_sync_q <= 1'b0;
      armed_a_q  <= 1'b0;
      armed_b_q  <= 1'b0;
      in0sel_q   <= SRC_DIN;
      stall_q    <= 1'b0;
      sw_cnt_q   <= 8'd0;
    end else begin
      out_data_q <= out_data_d;
      out_clk_q  <= out_clk_d;
      out_sync_q <= out_sync_d;
      armed_a_q  <= armed_a_d;
      armed_b_q  <= armed_b_d;
      in0sel_q   <= in0sel_d;
      stall_q    <= stall_d;
      sw_cnt_q   <= sw_cnt_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_clk      = out_clk_q;
  assign out_sync     = out_sync_q;
  assign in0selected  = in0sel_q;
  assign stall_err    = stall_q;
  assign switch_count = sw_cnt_q;

endmodule

// File: tb/tb_tt_um_hoene_input_arbiter.sv
// Directed bench for the input arbiter: grant latency, guard gap, priority, watchdog,
// reset with sync held high and switch-count saturation.
module tb_tt_um_hoene_input_arbiter;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       a_data = 1'b0, a_clk = 1'b0, a_sync = 1'b0;
  logic       b_data = 1'b0, b_clk = 1'b0, b_sync = 1'b0;
  logic       out_data, out_clk, out_sync, in0selected, stall_err;
  logic [7:0] switch_count;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  tt_um_hoene_input_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_data       (a_data),
    .a_clk        (a_clk),
    .a_sync       (a_sync),
    .b_data       (b_data),
    .b_clk        (b_clk),
    .b_sync       (b_sync),
    .out_data     (out_data),
    .out_clk      (out_clk),
    .out_sync     (out_sync),
    .in0selected  (in0selected),
    .stall_err    (stall_err),
    .switch_count (switch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_guard();
    repeat (20) tick();
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst_n = 1'b0;
    repeat (3) tick();
    obs = {out_data, out_clk, out_sync, in0selected, stall_err, switch_count};
    checks++;
    if (obs !== 13'b0_0_0_1_0_00000000) begin
      errors++;
      $display("FAIL reset_state: got %b want 0001000000000", obs);
    end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_grant_a();
    int pulses = 0;
    int bad = 0;
    a_sync = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a_clk  = (i >= 4 && i < 36);
      a_data = (i % 3 == 0);
      tick();
      if (i == 0) begin
        checks++;
        if (out_sync !== 1'b0) begin errors++; $display("FAIL grant_latency_early: out_sync %b want 0", out_sync); end
      end
      if (i == 1) begin
        checks++;
        if (out_sync !== 1'b1) begin errors++; $display("FAIL grant_latency: out_sync %b want 1", out_sync); end
      end
      if (i >= 1 && (out_clk !== a_clk || out_data !== a_data || out_sync !== 1'b1)) bad++;
      if (out_clk === 1'b1) pulses++;
    end
    a_sync = 1'b0; a_clk = 1'b0; a_data = 1'b0;
    tick();
    if (out_clk === 1'b1) pulses++;
    checks++;
    if (pulses != 32) begin errors++; $display("FAIL a_pulse_count: got %0d want 32", pulses); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL a_forwarding: %0d bad cycles want 0", bad); end
    checks++;
    if (out_sync !== 1'b0) begin errors++; $display("FAIL a_release: out_sync %b want 0", out_sync); end
    checks++;
    if (in0selected !== 1'b1 || switch_count !== 8'd0) begin
      errors++; $display("FAIL a_stats: in0sel %b cnt %0d want 1 0", in0selected, switch_count);
    end
  endtask

  task automatic test_switch_b();
    int n = 0;
    tick(); tick();
    b_sync = 1'b1;
    while (out_sync !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != 16) begin errors++; $display("FAIL b_guard_wait: took %0d want 16", n); end
    checks++;
    if (in0selected !== 1'b0 || switch_count !== 8'd1) begin
      errors++; $display("FAIL b_stats: in0sel %b cnt %0d want 0 1", in0selected, switch_count);
    end
    for (int i = 0; i < 6; i++) begin b_clk = i[0]; b_data = 1'b1; tick(); end
    b_clk = 1'b1; b_sync = 1'b0;
    tick();
    checks++;
    if (out_clk !== 1'b1 || out_sync !== 1'b1) begin
      errors++; $display("FAIL b_last_strobe: clk %b sync %b want 1 1", out_clk, out_sync);
    end
    b_clk = 1'b0; b_data = 1'b0;
    tick();
    checks++;
    if (out_clk !== 1'b0 || out_sync !== 1'b0) begin
      errors++; $display("FAIL b_after_release: clk %b sync %b want 0 0", out_clk, out_sync);
    end
    wait_guard();
  endtask

  task automatic test_priority();
    int bad = 0;
    a_sync = 1'b1; b_sync = 1'b1;
    tick(); tick();
    checks++;
    if (out_sync !== 1'b1 || in0selected !== 1'b1 || switch_count !== 8'd2) begin
      errors++; $display("FAIL priority_grant: sync %b in0sel %b cnt %0d want 1 1 2", out_sync, in0selected, switch_count);
    end
    for (int i = 0; i < 10; i++) begin
      b_clk = i[0]; b_data = 1'b1;
      tick();
      if (out_clk === 1'b1 || out_data === 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL priority_b_leak: %0d cycles want 0", bad); end
    a_sync = 1'b0; b_sync = 1'b0; b_clk = 1'b0; b_data = 1'b0;
    tick();
    wait_guard();
  endtask

  task automatic test_timeout();
    int n = 0;
    int hi = 0;
    a_sync = 1'b1;
    while (stall_err !== 1'b1 && n < 1200) begin tick(); n++; end
    checks++;
    if (n != 1025) begin errors++; $display("FAIL timeout_cycle: took %0d want 1025", n); end
    checks++;
    if (out_sync !== 1'b0) begin errors++; $display("FAIL timeout_out_sync: %b want 0", out_sync); end
    repeat (40) begin tick(); if (out_sync === 1'b1) hi++; end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL timeout_regrant: %0d sync cycles want 0", hi); end
    a_sync = 1'b0; tick();
    a_sync = 1'b1; tick(); tick();
    checks++;
    if (out_sync !== 1'b1 || stall_err !== 1'b1 || switch_count !== 8'd2) begin
      errors++; $display("FAIL timeout_rearm: sync %b stall %b cnt %0d want 1 1 2", out_sync, stall_err, switch_count);
    end
    a_sync = 1'b0; tick();
    wait_guard();
  endtask

  task automatic test_reset_midframe();
    logic [12:0] obs;
    int hi = 0;
    a_sync = 1'b1; tick(); tick();
    checks++;
    if (out_sync !== 1'b1) begin errors++; $display("FAIL midframe_grant: out_sync %b want 1", out_sync); end
    b_sync = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    obs = {out_data, out_clk, out_sync, in0selected, stall_err, switch_count};
    checks++;
    if (obs !== 13'b0_0_0_1_0_00000000) begin
      errors++; $display("FAIL async_reset: got %b want 0001000000000", obs);
    end
    a_sync = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (30) begin tick(); if (out_sync === 1'b1) hi++; end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL unarmed_b_granted: %0d sync cycles want 0", hi); end
    b_sync = 1'b0; tick();
    b_sync = 1'b1; tick(); tick();
    checks++;
    if (out_sync !== 1'b1 || in0selected !== 1'b0 || switch_count !== 8'd1) begin
      errors++; $display("FAIL b_after_rearm: sync %b in0sel %b cnt %0d want 1 0 1", out_sync, in0selected, switch_count);
    end
    b_sync = 1'b0; tick();
    wait_guard();
  endtask

  task automatic test_saturation();
    int n;
    int exp_cnt;
    logic use_a;
    for (int k = 1; k <= 300; k++) begin
      use_a = (k % 2 == 1);
      if (use_a) a_sync = 1'b1; else b_sync = 1'b1;
      n = 0;
      while (out_sync !== 1'b1 && n < 60) begin tick(); n++; end
      checks++;
      if (n >= 60) begin errors++; $display("FAIL sat_grant_timeout: frame %0d not granted", k); end
      if (use_a) a_clk = 1'b1; else b_clk = 1'b1;
      tick();
      a_clk = 1'b0; b_clk = 1'b0; a_sync = 1'b0; b_sync = 1'b0;
      tick();
      exp_cnt = (k + 1 > 255) ? 255 : k + 1;
      checks++;
      if (switch_count !== 8'(exp_cnt) || in0selected !== use_a) begin
        errors++;
        $display("FAIL sat_count: frame %0d cnt %0d in0sel %b want %0d %b", k, switch_count, in0selected, exp_cnt, use_a);
      end
    end
    wait_guard();
  endtask

  initial begin
    test_reset();
    test_grant_a();
    test_switch_b();
    test_priority();
    test_timeout();
    test_reset_midframe();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
